// File: rtl/ks_adder_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ks_adder_pkg
// Brief    : Shared types and elaboration helpers for the pipelined KS adder.
// Revision : 1.0
// ============================================================================
package ks_adder_pkg;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int LEVELS(input int width);
    return clog2(width);
  endfunction

  function automatic int LATENCY(input int width, input int reg_every);
    return 2 + (LEVELS(width) + reg_every - 1) / reg_every;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ks_prefix_level.sv
`default_nettype none
// ============================================================================
// Module   : ks_prefix_level
// Brief    : One combinational Kogge-Stone prefix level with span SPAN.
// Revision : 1.0
// ============================================================================
module ks_prefix_level
  import ks_adder_pkg::*;
#(
  parameter int WIDTH = 28,
  parameter int SPAN  = 1
) (
  input  pg_t [WIDTH-1:0] i_pg,
  output pg_t [WIDTH-1:0] o_pg
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i < SPAN) begin : g_pass
      assign o_pg[i] = i_pg[i];
    end else if (i < 2 * SPAN) begin : g_gray
      // Group already reaches bit 0 (carry-in folded there), so only G matters.
      assign o_pg[i].g = i_pg[i].g | (i_pg[i].p & i_pg[i-SPAN].g);
      assign o_pg[i].p = i_pg[i].p;
    end else begin : g_black
      assign o_pg[i].g = i_pg[i].g | (i_pg[i].p & i_pg[i-SPAN].g);
      assign o_pg[i].p = i_pg[i].p & i_pg[i-SPAN].p;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ks_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ks_adder_pipe
// Brief    : Pipelined Kogge-Stone add/sub with valid/ready; KSA_OVF_EN adds
//            a registered signed-overflow flag (tied low otherwise).
// Revision : 1.0
// ============================================================================
module ks_adder_pipe
  import ks_adder_pkg::*;
#(
  parameter int WIDTH     = 28,
  parameter int REG_EVERY = 2,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic [TAG_W-1:0] tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [TAG_W-1:0] tag_out
);

  localparam int c_LEVELS = LEVELS(WIDTH);
  localparam int c_NREG   = (c_LEVELS + REG_EVERY - 1) / REG_EVERY;

  logic             w_adv;
  logic [WIDTH-1:0] w_bx;
  logic             w_c0;
  pg_t  [WIDTH-1:0] w_pg0;

  // Stage 0 is the PG register; stages 1..c_NREG follow prefix groups.
  logic             r_vld [0:c_NREG];
  logic [TAG_W-1:0] r_tag [0:c_NREG];
  logic [WIDTH-1:0] r_po  [0:c_NREG];
  logic             r_c0  [0:c_NREG];
  pg_t  [WIDTH-1:0] r_pg  [0:c_NREG];

  pg_t  [WIDTH-1:0] w_lin [0:c_LEVELS-1];
  pg_t  [WIDTH-1:0] w_lvl [0:c_LEVELS-1];
  pg_t  [WIDTH-1:0] w_grp [1:c_NREG];

  logic [WIDTH-1:0] w_carry;
  logic [WIDTH-1:0] w_pend;
  logic [WIDTH-1:0] w_sum;
  logic             w_unused_p;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic [TAG_W-1:0] r_tag_out;

  assign w_adv    = ~r_out_valid | out_ready;
  assign in_ready = w_adv;

  always_comb begin
    w_bx = sub ? ~b : b;
    w_c0 = sub | cin;
    for (int i = 0; i < WIDTH; i++) begin
      w_pg0[i].p = a[i] ^ w_bx[i];
      w_pg0[i].g = a[i] & w_bx[i];
    end
    // Fold carry-in into bit 0 so every prefix G output is a true carry.
    w_pg0[0].g = w_pg0[0].g | (w_pg0[0].p & w_c0);
  end

  for (genvar k = 0; k < c_LEVELS; k++) begin : g_level
    if (k % REG_EVERY == 0) begin : g_from_reg
      assign w_lin[k] = r_pg[k / REG_EVERY];
    end else begin : g_from_comb
      assign w_lin[k] = w_lvl[k-1];
    end
    ks_prefix_level #(
      .WIDTH (WIDTH),
      .SPAN  (1 << k)
    ) u_level (
      .i_pg (w_lin[k]),
      .o_pg (w_lvl[k])
    );
  end

  for (genvar j = 1; j <= c_NREG; j++) begin : g_stage
    localparam int c_SRC = (((j * REG_EVERY) < c_LEVELS) ? (j * REG_EVERY) : c_LEVELS) - 1;
    assign w_grp[j] = w_lvl[c_SRC];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j <= c_NREG; j++) begin
        r_vld[j] <= 1'b0;
        r_tag[j] <= '0;
        r_po[j]  <= '0;
        r_c0[j]  <= 1'b0;
        r_pg[j]  <= '0;
      end
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_tag_out   <= '0;
    end else if (w_adv) begin
      r_vld[0] <= in_valid;
      r_tag[0] <= tag;
      r_po[0]  <= a ^ w_bx;
      r_c0[0]  <= w_c0;
      r_pg[0]  <= w_pg0;
      for (int j = 1; j <= c_NREG; j++) begin
        r_vld[j] <= r_vld[j-1];
        r_tag[j] <= r_tag[j-1];
        r_po[j]  <= r_po[j-1];
        r_c0[j]  <= r_c0[j-1];
        r_pg[j]  <= w_grp[j];
      end
      r_out_valid <= r_vld[c_NREG];
      r_sum       <= w_sum;
      r_cout      <= w_carry[WIDTH-1];
      r_tag_out   <= r_tag[c_NREG];
    end
  end

  always_comb begin
    w_carry = '0;
    w_pend  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_carry[i] = r_pg[c_NREG][i].g;
      w_pend[i]  = r_pg[c_NREG][i].p;
    end
  end

  // Group-propagate bits of the final level have no consumer.
  assign w_unused_p = ^w_pend;
  assign w_sum      = r_po[c_NREG] ^ {w_carry[WIDTH-2:0], r_c0[c_NREG]};

`ifdef KSA_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      r_ovf <= w_carry[WIDTH-1] ^ w_carry[WIDTH-2];
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign tag_out   = r_tag_out;

endmodule
`default_nettype wire

// File: tb/tb_ks_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ks_adder_pipe
// Brief    : Self-checking bench: 28-bit/REG_EVERY=2 and 64-bit/REG_EVERY=1.
// Revision : 1.0
// ============================================================================
module tb_ks_adder_pipe;

`ifdef KSA_OVF_EN
  localparam bit c_ovf = 1'b1;
`else
  localparam bit c_ovf = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [27:0] a, b, sum;
  logic [3:0]  tag, tag_out;

  logic        in_valid2, in_ready2, cin2, sub2, out_valid2, out_ready2, cout2, ovf2;
  logic [63:0] a2, b2, sum2;
  logic [3:0]  tag2, tag_out2;

  int total = 0;
  int bad   = 0;
  int n_pop = 0;
  bit sb_on = 1'b0;
  bit stall_en = 1'b0;
  logic [33:0] q[$];

  always #5 clk = ~clk;

  ks_adder_pipe #(.WIDTH(28), .REG_EVERY(2), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .tag(tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .tag_out(tag_out)
  );

  ks_adder_pipe #(.WIDTH(64), .REG_EVERY(1), .TAG_W(4)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .cin(cin2), .sub(sub2), .tag(tag2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .sum(sum2), .cout(cout2), .ovf(ovf2), .tag_out(tag_out2)
  );

  // Reference: {tag, raw signed overflow, cout, sum} from plain arithmetic.
  function automatic logic [33:0] model(input logic [27:0] ma, input logic [27:0] mb,
                                        input logic mc, input logic ms, input logic [3:0] mt);
    logic [27:0] bb;
    logic [28:0] full;
    logic        sv;
    bb   = ms ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, bb} + {28'd0, ms | mc};
    sv   = (ma[27] == bb[27]) && (full[27] != ma[27]);
    return {mt, sv, full};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard and per-cycle protocol checks for the 28-bit instance.
  initial begin
    logic [33:0] e, h, cur;
    bit held;
    held = 1'b0;
    h = '0;
    forever begin
      @(negedge clk);
      if (!sb_on) begin
        held = 1'b0;
      end else if (rst) begin
        q.delete();
        held = 1'b0;
      end else begin
        cur = {tag_out, ovf, cout, sum};
        if (held) chk("stall_hold", 64'(cur), 64'(h));
        held = out_valid && !out_ready;
        h = cur;
        chk("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got sum %0h with no pending transaction", sum);
          end else begin
            e = q.pop_front();
            n_pop++;
            chk("result", 64'(cur), 64'({e[33:30], e[29] & c_ovf, e[28:0]}));
          end
        end
        if (in_valid && in_ready) q.push_back(model(a, b, cin, sub, tag));
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stall_en) out_ready = ($urandom_range(0, 1) == 1);
    end
  end

  task automatic drive(input logic [27:0] ta, input logic [27:0] tb_, input logic tc,
                       input logic ts, input logic [3:0] tt);
    int n;
    n = 0;
    a = ta; b = tb_; cin = tc; sub = ts; tag = tt; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("drive_timeout", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic latency_run(input logic [27:0] ta, input logic [27:0] tb_, input logic tc,
                             input logic ts, input logic [3:0] tt, output int lat);
    @(posedge clk);
    #1;
    a = ta; b = tb_; cin = tc; sub = ts; tag = tt; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 50) begin
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic latency_run2(input logic [63:0] ta, input logic [63:0] tb_, input logic tc,
                              input logic ts, input logic [3:0] tt, output int lat);
    @(posedge clk);
    #1;
    a2 = ta; b2 = tb_; cin2 = tc; sub2 = ts; tag2 = tt; in_valid2 = 1'b1;
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid2 && lat < 50) begin
      lat++;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat, n, p0;
    logic [33:0] m;
    logic [31:0] r1, r2, r3;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; tag = '0;
    out_ready = 1'b1;
    in_valid2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0; sub2 = 1'b0; tag2 = '0;
    out_ready2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_outputs", 64'({tag_out, ovf, cout, sum}), 64'(0));
    chk("rst_out_valid64", 64'(out_valid2), 64'(0));
    sb_on = 1'b1;

    m = model(28'h0FFFFFF, 28'h0000001, 1'b0, 1'b0, 4'h0);
    chk("model_carry", 64'(m[28:0]), 64'({1'b0, 28'h1000000}));
    m = model(28'h7FFFFFF, 28'hFFFFFFF, 1'b0, 1'b1, 4'h0);
    chk("model_ovf", 64'(m[29]), 64'(1));
    m = model(28'd5, 28'd7, 1'b0, 1'b1, 4'h3);
    chk("model_sub", 64'(m), 64'({4'h3, 1'b0, 1'b0, 28'hFFFFFFE}));

    latency_run(28'h0FFFFFF, 28'h0000001, 1'b0, 1'b0, 4'h1, lat);
    chk("lat_w28", 64'(lat), 64'(5));
    chk("sum_carry_chain", 64'(sum), 64'(28'h1000000));
    chk("cout_carry_chain", 64'(cout), 64'(0));

    latency_run(28'hFFFFFFF, 28'h0000000, 1'b1, 1'b0, 4'h2, lat);
    chk("sum_wrap", 64'(sum), 64'(0));
    chk("cout_wrap", 64'(cout), 64'(1));
    chk("ovf_wrap", 64'(ovf), 64'(0));

    latency_run(28'd5, 28'd7, 1'b1, 1'b1, 4'h3, lat);
    chk("sum_sub", 64'(sum), 64'(28'hFFFFFFE));
    chk("cout_sub", 64'(cout), 64'(0));
    chk("tag_sub", 64'(tag_out), 64'(4'h3));

    latency_run(28'h7FFFFFF, 28'hFFFFFFF, 1'b0, 1'b1, 4'h4, lat);
    chk("sum_ovf", 64'(sum), 64'(28'h8000000));
    chk("ovf_sub", 64'(ovf), 64'(c_ovf));

    // Random back-to-back stream with pseudo-random back-pressure.
    @(posedge clk);
    #1;
    p0 = n_pop;
    stall_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      r1 = $urandom();
      r2 = $urandom();
      r3 = $urandom();
      drive(r1[27:0], r2[27:0], r3[0], r3[1], r3[7:4]);
    end
    stall_en = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("stream_drain", 64'(q.size()), 64'(0));
    chk("stream_count", 64'(n_pop - p0), 64'(20));

    // Reset with three transactions in flight.
    @(posedge clk);
    #1;
    drive(28'h0000011, 28'h0000022, 1'b0, 1'b0, 4'h5);
    drive(28'h0000033, 28'h0000044, 1'b0, 1'b0, 4'h6);
    drive(28'h0000055, 28'h0000066, 1'b0, 1'b0, 4'h7);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'(0));
    chk("flush_in_ready", 64'(in_ready), 64'(1));
    chk("flush_outputs", 64'({tag_out, ovf, cout, sum}), 64'(0));
    repeat (10) @(negedge clk);
    latency_run(28'h0000100, 28'h0000200, 1'b1, 1'b0, 4'h9, lat);
    chk("lat_after_reset", 64'(lat), 64'(5));
    chk("sum_after_reset", 64'(sum), 64'(28'h0000301));
    chk("tag_after_reset", 64'(tag_out), 64'(4'h9));

    // 64-bit instance, one register per prefix level.
    latency_run2(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 4'hA, lat);
    chk("lat_w64", 64'(lat), 64'(8));
    chk("sum_w64", sum2, 64'h0);
    chk("cout_w64", 64'(cout2), 64'(1));
    chk("ovf_w64", 64'(ovf2), 64'(0));
    chk("tag_w64", 64'(tag_out2), 64'(4'hA));
    latency_run2(64'h0, 64'h1, 1'b0, 1'b1, 4'hB, lat);
    chk("sum_w64_sub", sum2, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("cout_w64_sub", 64'(cout2), 64'(0));

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, limit 500000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/ks_adder_pipe.md
# ks_adder_pipe

Parametrised, pipelined Kogge-Stone adder/subtractor with a valid/ready handshake. It is the successor to the fixed 28-bit combinational Kogge-Stone datapath. Width, register placement inside the prefix tree, and a sideband tag are parameters, and add or subtract is selectable per transaction. It sits between the operand-alignment stage and the normaliser in the floating-point mantissa path.

## Interface
- WIDTH, 28: operand/sum width in bits; legal range 4..64.
- REG_EVERY, 2: number of prefix levels between pipeline registers; legal range 1..LEVELS.
- TAG_W, 4: sideband tag width; legal range 1..16.
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- IN_VALID  in  1  operand transfer request.
- IN_READY  out  1  block accepts operands this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- CIN  in  1  carry-in; ignored when SUB=1.
- SUB  in  1  1 = compute A + ~B + 1.
- TAG  in  TAG_W  opaque tag, returned with the result.
- OUT_VALID  out  1  result available.
- OUT_READY  in  1  consumer accepts result.
- SUM  out  WIDTH  result, modulo 2^WIDTH.
- COUT  out  1  carry out of bit WIDTH-1.
- OVF  out  1  signed overflow (see Configuration).
- TAG_OUT  out  TAG_W  tag of the current result.

## Operation
- LEVELS = clog2(WIDTH): 5 for WIDTH=28, 6 for WIDTH=64.
- Stage P (PG layer):
  - B' = SUB ? ~B : B.
  - c0 = SUB ? 1 : CIN.
  - Pi = Ai ^ B'i and Gi = Ai & B'i.
  - The c0 input is folded in as G[-1], so every prefix output is a true carry.
- Prefix levels k = 0..LEVELS-1 use span 2^k.
  - Gray cell when the span reaches G[-1]; black cell otherwise.
  - Bits with i < 2^k pass through unchanged.
- Sum layer:
  - SUM[0] = P0 ^ c0.
  - SUM[i] = Pi ^ C[i-1].
  - COUT = C[WIDTH-1].
- Pipeline registers sit at three places:
  - after stage P;
  - after every REG_EVERY prefix levels, and after the last prefix level;
  - on the outputs (SUM/COUT/OVF/TAG_OUT).
- Each stage carries a valid bit, and the tag travels with the data.
- Flow control: ADV = ~OUT_VALID | OUT_READY.
  - IN_READY = ADV.
  - All stages advance together when ADV=1 and hold when ADV=0.
  - Bubbles are not collapsed.
- An input is accepted on a cycle with IN_VALID & IN_READY.
- An output is consumed on a cycle with OUT_VALID & OUT_READY.
- Simultaneous accept and consume in one cycle is legal and sustains one result per cycle.
- While OUT_VALID=1 and OUT_READY=0:
  - SUM/COUT/OVF/TAG_OUT hold stable;
  - IN_VALID is ignored because IN_READY=0.
- Results leave in acceptance order. No reordering and no drop.

## Timing
- Latency LAT = 2 + ceil(LEVELS/REG_EVERY) cycles, from the accepting edge to the edge where OUT_VALID rises, with no stall.
  - WIDTH=28, REG_EVERY=2: LAT=5.
  - WIDTH=28, REG_EVERY=5: LAT=3.
- Throughput: 1 result per cycle while OUT_READY=1.
- A stall of N cycles delays every in-flight result by exactly N cycles.
- Reset values (apply on the cycle after RST is sampled high):
  - all stage valid bits 0;
  - OUT_VALID=0 and IN_READY=1;
  - SUM=0, COUT=0, OVF=0, TAG_OUT=0;
  - all data registers 0.
- Reset mid-operation discards all in-flight transactions silently. The first input accepted after RST deasserts appears LAT cycles later.

## Configuration
- KSA_OVF_EN defined:
  - OVF = C[WIDTH-1] ^ C[WIDTH-2], the carries into and out of the MSB;
  - OVF is registered with SUM.
- KSA_OVF_EN undefined:
  - the OVF port still exists and is tied to 0;
  - no overflow logic is synthesised.

## Structure
- Package ks_adder_pkg holds:
  - clog2 function;
  - LEVELS(WIDTH) and LATENCY(WIDTH, REG_EVERY) functions;
  - a pg_t struct {p, g} used for stage registers.
- One sub-module, ks_prefix_level:
  - parameters WIDTH and SPAN;
  - combinational; maps G/P vectors in to G/P vectors out for one level;
  - instantiated LEVELS times via generate.
- Register insertion is selected by (k+1) % REG_EVERY == 0, or k == LEVELS-1.

## Test plan
- WIDTH=28, REG_EVERY=2: A=0x0FFFFFF, B=0x0000001, CIN=0, SUB=0 -> SUM=0x1000000, COUT=0, OUT_VALID exactly 5 cycles after accept.
- A=0xFFFFFFF, B=0x0000000, CIN=1 -> SUM=0x0000000, COUT=1; with KSA_OVF_EN, OVF=0.
- SUB=1, A=5, B=7, TAG=0x3 -> SUM=0xFFFFFFE, COUT=0, TAG_OUT=0x3; with KSA_OVF_EN, A=0x7FFFFFF, B=0xFFFFFFF (i.e. -1) -> OVF=1.
- Stream 20 back-to-back random transactions with OUT_READY toggled pseudo-randomly -> all 20 results in order, matching (A ± B + c0) mod 2^28; outputs stable while stalled.
- Assert RST for 1 cycle while 3 transactions are in flight -> OUT_VALID=0 next cycle, none of the 3 results ever appears, IN_READY=1.
- WIDTH=64, REG_EVERY=1: A=2^64-1, B=1 -> SUM=0, COUT=1, latency 8 cycles.
